// File: rtl/fb_write_coalescer.sv
// Packs single-pixel framebuffer writes into strobed 128-bit line beats.
// It drives independent data/address handshakes and drains on frame flush.
module fb_write_coalescer #(
    parameter int PIX_WIDTH      = 16,
    parameter int PIX_ADDR_WIDTH = 25,
    parameter int ADDR_WIDTH     = 27
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      pix_valid_in,
    output logic                      pix_ready_out,
    input  logic [PIX_ADDR_WIDTH-1:0] pix_addr_in,
    input  logic [PIX_WIDTH-1:0]      pix_data_in,
    input  logic                      flush_in,
    output logic [143:0]              write_data_out,
    output logic                      data_valid_out,
    input  logic                      data_ready_in,
    output logic [ADDR_WIDTH-1:0]     write_addr_out,
    output logic                      addr_valid_out,
    input  logic                      addr_ready_in,
    output logic                      last_write_out,
    output logic                      frame_done_out
);
    localparam int LANES     = 128 / PIX_WIDTH;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int LINE_BITS = PIX_ADDR_WIDTH - LANE_BITS;
    localparam int STRB_LANE = PIX_WIDTH / 8;

    logic [127:0]           r_acc_line;
    logic [15:0]            r_acc_strb;
    logic [LINE_BITS-1:0]   r_acc_idx;
    logic [143:0]           r_slot_data;
    logic [LINE_BITS-1:0]   r_slot_idx;
    logic                   r_dv;
    logic                   r_av;
    logic                   r_slot_last;
    logic                   r_flush_pending;

    logic [LANE_BITS-1:0]   w_lane;
    logic [LINE_BITS-1:0]   w_pix_idx;
    logic [127:0]           w_pix_mask;
    logic [127:0]           w_pix_line;
    logic [15:0]            w_pix_strb;
    logic [127:0]           w_merge_line;
    logic [15:0]            w_merge_strb;
    logic                   w_acc_empty;
    logic                   w_acc_full;
    logic                   w_slot_free;
    logic                   w_slot_empty;
    logic                   w_diff;
    logic                   w_pix_fire;
    logic                   w_evict;
    logic                   w_move;

    assign w_lane    = pix_addr_in[LANE_BITS-1:0];
    assign w_pix_idx = pix_addr_in[PIX_ADDR_WIDTH-1:LANE_BITS];

    always_comb begin
        w_pix_mask = '0;
        w_pix_line = '0;
        w_pix_strb = '0;
        w_pix_mask[w_lane*PIX_WIDTH +: PIX_WIDTH] = '1;
        w_pix_line[w_lane*PIX_WIDTH +: PIX_WIDTH] = pix_data_in;
        w_pix_strb[w_lane*STRB_LANE +: STRB_LANE] = '1;
    end

    assign w_acc_empty  = (r_acc_strb == '0);
    assign w_acc_full   = &r_acc_strb;
    // Free if each outstanding handshake is either already done or completes now.
    assign w_slot_free  = (!r_dv || data_ready_in) && (!r_av || addr_ready_in);
    assign w_slot_empty = !r_dv && !r_av;
    assign w_diff       = !w_acc_empty && (w_pix_idx != r_acc_idx);

    assign pix_ready_out = !rst_in && !r_flush_pending && !(w_diff && !w_slot_free);
    assign w_pix_fire    = pix_valid_in && pix_ready_out;
    assign w_evict       = w_pix_fire && w_diff;
    assign w_move        = !w_acc_empty && w_slot_free &&
                           (w_evict || w_acc_full || r_flush_pending);

    assign w_merge_line = w_pix_fire ? ((r_acc_line & ~w_pix_mask) | w_pix_line) : r_acc_line;
    assign w_merge_strb = w_pix_fire ? (r_acc_strb | w_pix_strb) : r_acc_strb;

    assign frame_done_out = r_flush_pending && w_acc_empty && w_slot_empty;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc_line <= '0;
            r_acc_strb <= '0;
            r_acc_idx  <= '0;
        end else if (w_move) begin
            // An eviction restarts the accumulator with the incoming pixel alone.
            if (w_evict) begin
                r_acc_line <= w_pix_line;
                r_acc_strb <= w_pix_strb;
                r_acc_idx  <= w_pix_idx;
            end else begin
                r_acc_line <= '0;
                r_acc_strb <= '0;
            end
        end else if (w_pix_fire) begin
            r_acc_line <= w_merge_line;
            r_acc_strb <= w_merge_strb;
            r_acc_idx  <= w_pix_idx;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_slot_data <= '0;
            r_slot_idx  <= '0;
            r_dv        <= 1'b0;
            r_av        <= 1'b0;
            r_slot_last <= 1'b0;
        end else if (w_move) begin
            // A same-line pixel arriving with a full-line transfer rides along in the beat.
            r_slot_data <= w_evict ? {r_acc_line, r_acc_strb} : {w_merge_line, w_merge_strb};
            r_slot_idx  <= r_acc_idx;
            r_dv        <= 1'b1;
            r_av        <= 1'b1;
            r_slot_last <= r_flush_pending;
        end else begin
            if (data_ready_in) r_dv <= 1'b0;
            if (addr_ready_in) r_av <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_flush_pending <= 1'b0;
        else if (frame_done_out)
            r_flush_pending <= 1'b0;
        else if (flush_in)
            r_flush_pending <= 1'b1;
    end

    assign write_data_out = r_slot_data;
    assign write_addr_out = {{(ADDR_WIDTH-LINE_BITS){1'b0}}, r_slot_idx};
    assign data_valid_out = r_dv;
    assign addr_valid_out = r_av;
    assign last_write_out = r_slot_last && (r_dv || r_av);

endmodule

// File: doc/fb_write_coalescer.md
Name: fb_write_coalescer

Overview:
- Packs single-pixel framebuffer writes from the rasteriser into 128-bit DDR line writes with byte strobes.
- Sits directly upstream of the DDR write path and drives its separate write-data and write-address FIFO handshakes.
- Beat format: 144-bit data beat = {128-bit pixel line, 16-bit byte strobe}; address = 128-bit line index.
- A frame flush drains the partial line, marks it last and reports frame completion.

Parameters:
- PIX_WIDTH, 16, bits per pixel; fixed 128/PIX_WIDTH = 8 lanes per line.
- PIX_ADDR_WIDTH, 25, pixel index width; line index = pix_addr_in[24:3], lane = pix_addr_in[2:0].
- ADDR_WIDTH, 27, width of write_addr_out; line index zero-extended.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  asynchronous, active-high reset.
- pix_valid_in  in  1  pixel write request.
- pix_ready_out  out  1  pixel accepted when valid&ready.
- pix_addr_in  in  PIX_ADDR_WIDTH  pixel index.
- pix_data_in  in  PIX_WIDTH  pixel colour.
- flush_in  in  1  one-cycle end-of-frame pulse.
- write_data_out  out  144  {line[127:0], strobe[15:0]}.
- data_valid_out  out  1  data beat valid.
- data_ready_in  in  1  data FIFO ready.
- write_addr_out  out  ADDR_WIDTH  line index of the current beat.
- addr_valid_out  out  1  address valid.
- addr_ready_in  in  1  address FIFO ready.
- last_write_out  out  1  beat is the flush beat of the frame.
- frame_done_out  out  1  one-cycle pulse: flush fully drained.

Behaviour:
- Reset: all valids, last_write_out, frame_done_out = 0; accumulator empty (strobe 0); output slot empty; flush_pending = 0. pix_ready_out = 1 after reset.
- Lane mapping: lane k occupies line bits [16k+15:16k] and strobe bits [2k+1:2k]. Accepting a pixel writes its data and sets both strobe bits of its lane. A repeat write to the same lane overwrites it (last write wins).
- Output slot is free when empty, or when both outstanding handshakes complete this cycle. Each handshake may complete in an earlier cycle or the current one.
- On load, the slot sets data_valid_out and addr_valid_out together. Each valid drops independently after its own valid&ready; the slot empties once both have fired. Beat contents are stable while either valid is high.
- Eviction of a different line:
  - Applies when an accepted pixel's line differs from a non-empty accumulator.
  - If the slot is free, the accumulator moves to the slot on that same edge.
  - The accumulator reloads with the new pixel only (one lane strobed), so there is zero bubble.
  - If the slot is not free, pix_ready_out = 0.
- Full line: when the strobe is 16'hFFFF, the accumulator moves to the slot on the next edge the slot is free. pix_ready_out stays 1 for same-line pixels until that transfer.
- Latency: a pixel that completes a line, accepted at edge E, gives valids high after edge E+1 when the slot is free.
- Flush:
  - flush_in sets flush_pending. A pixel accepted in the same cycle is included before the flush.
  - While flush_pending, pix_ready_out = 0.
  - A non-empty accumulator moves to the slot with last_write_out = 1.
  - Once the accumulator and slot are both empty, frame_done_out pulses for 1 cycle and flush_pending clears.
  - Flush with an empty accumulator produces no beat and no last; frame_done_out still waits for the slot to drain.
  - A flush_in while flush_pending is already set is ignored.
- Partial strobes: empty lanes have data 0 and strobe 0. A beat with strobe 0 is never emitted.
- Reset mid-operation: the accumulator and slot contents are discarded; no beat completes.

Test Plan:
- 8 pixels at addrs 0..7, data 16'h1000+i, both readys high → one beat: line = {16'h1007..16'h1000}, strobe 16'hFFFF, addr 0, last 0, valids one cycle after the 8th accept.
- Pixels at addrs 8 then 24, then flush → beat 1: addr 1, strobe 16'h0003. Beat 2: addr 3, strobe 16'h0003, last 1. frame_done_out pulses once after beat 2's last handshake.
- Handshake skew: addr_ready_in high, data_ready_in low for 5 cycles → addr_valid_out drops after 1 cycle, data_valid_out held with stable data. A different-line pixel stalls (pix_ready_out = 0) until data completes.
- Addr 5 written with 16'hAAAA, then 16'h5555, then flush → strobe 16'h0C00, lane 5 = 16'h5555.
- Flush with empty accumulator and empty slot → no valids; frame_done_out pulses the cycle after flush. pix_ready_out low for exactly that cycle.
- Reset asserted while a beat is pending with data_ready_in low → all outputs 0 immediately; after release, pix_ready_out = 1 and no stale beat appears.
